ps2_host_ctrl: RTL and testbench

Host-side command sequencer for the PS/2 keyboard port. Sits between the PS/2 byte transceiver and the scancode decoder. Serialises host-to-device commands (keyboard reset, LED update) onto the single transmit path, waits for and consumes the device's protocol replies (ACK, RESEND, BAT result), and retries or times out. All other received bytes pass unchanged to the scancode decoder.

---
 rtl/ps2_host_ctrl_pkg.sv | 25 ++
 rtl/ps2_ms_timer.sv | 47 ++++
 rtl/ps2_host_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_ctrl_pkg.sv
// Shared PS/2 protocol bytes and sequencer state encoding for the host-side
// command controller.
package ps2_host_ctrl_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_TXWAIT   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_WAIT_BAT = 3'd4
    } state_e;

    // LED argument byte of the 0xED command: {5'b0, caps, num, scroll}
    function automatic logic [7:0] led_byte(input logic [2:0] leds);
        return {5'b00000, leds};
    endfunction

endpackage

// File: rtl/ps2_ms_timer.sv
// Free-running 1 ms prescaler plus a saturating millisecond counter.
// expired_o rises once more than limit_i whole milliseconds have elapsed.
module ps2_ms_timer #(
    parameter int CLK_FREQ = 28000000,
    parameter int MS_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic [MS_W-1:0] limit_i,
    output logic            expired_o
);

    localparam int TICKS = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 2;
    localparam int PW    = $clog2(TICKS);

    logic [PW-1:0]   pre_q, pre_d;
    logic [MS_W-1:0] ms_q, ms_d;
    logic            tick;

    assign tick = (pre_q == PW'(TICKS - 1));

    // The prescaler never clears, so the first tick after clr_i lands
    // anywhere within the next millisecond: expiry is N to N+1 ms later.
    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        ms_d  = ms_q;
        if (clr_i) begin
            ms_d = '0;
        end else if (tick && (ms_q != '1)) begin
            ms_d = ms_q + MS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ms_q  <= ms_d;
        end
    end

    assign expired_o = (ms_q > limit_i);

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host command sequencer: sends reset / LED commands, consumes the
// device's ACK, RESEND and BAT replies, retries or times out, forwards the rest.
module ps2_host_ctrl
    import ps2_host_ctrl_pkg::*;
#(
    parameter int CLK_FREQ       = 28000000,
    parameter int ACK_TIMEOUT_MS = 20,
    parameter int BAT_TIMEOUT_MS = 1000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       tx_error,
    input  logic       led_req,
    input  logic [2:0] led_val,
    input  logic       kbd_reset_req,
    output logic [7:0] scan_data,
    output logic       scan_valid,
    output logic       cmd_busy,
    output logic       kbd_ok,
    output logic       kbd_fail
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e        state_q;
    logic [7:0]    tx_data_q, scan_data_q;
    logic          tx_start_q, scan_valid_q, cmd_busy_q, kbd_ok_q, kbd_fail_q;
    logic          rst_pend_q, led_pend_q, tx_busy_q;
    logic [2:0]    led_val_q;
    logic [RW-1:0] retry_q;

    logic        rx_ack, rx_resend, rx_bat_ok, rx_bat_fail;
    logic        in_wait_ack, in_wait_bat, consumed, tx_done, do_retry;
    logic        tmr_clr, tmr_expired;
    logic [15:0] tmr_limit;
    logic        unused_rx_error;

    // Frame errors are not acted on; a lost reply is caught by the timeout.
    assign unused_rx_error = rx_error;

    assign rx_ack      = rx_valid && (rx_data == RSP_ACK);
    assign rx_resend   = rx_valid && (rx_data == RSP_RESEND);
    assign rx_bat_ok   = rx_valid && (rx_data == RSP_BAT_OK);
    assign rx_bat_fail = rx_valid && (rx_data == RSP_BAT_FAIL);
    assign in_wait_ack = (state_q == ST_WAIT_ACK);
    assign in_wait_bat = (state_q == ST_WAIT_BAT);

    assign consumed = (in_wait_ack && (rx_ack || rx_resend)) ||
                      (in_wait_bat && (rx_bat_ok || rx_bat_fail));
    assign tx_done  = tx_busy_q && !tx_busy;
    // A reply arriving together with the timeout wins over it.
    assign do_retry = ((state_q == ST_TXWAIT) && tx_error) ||
                      (in_wait_ack && (rx_resend || (tmr_expired && !rx_ack)));

    // Timer runs only while waiting; an ACK restarts it for the BAT wait.
    assign tmr_clr   = !(in_wait_ack || in_wait_bat) || (in_wait_ack && rx_ack);
    assign tmr_limit = in_wait_bat ? 16'(BAT_TIMEOUT_MS) : 16'(ACK_TIMEOUT_MS);

    ps2_ms_timer #(
        .CLK_FREQ (CLK_FREQ),
        .MS_W     (16)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmr_clr),
        .limit_i   (tmr_limit),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
            cmd_busy_q   <= 1'b0;
            kbd_ok_q     <= 1'b0;
            kbd_fail_q   <= 1'b0;
            rst_pend_q   <= 1'b1;
            led_pend_q   <= 1'b0;
            led_val_q    <= '0;
            retry_q      <= '0;
            tx_busy_q    <= 1'b0;
        end else begin
            tx_start_q   <= 1'b0;
            tx_busy_q    <= tx_busy;
            scan_valid_q <= rx_valid && !consumed;
            if (rx_valid && !consumed) begin
                scan_data_q <= rx_data;
            end
            if (kbd_reset_req) begin
                rst_pend_q <= 1'b1;
            end
            if (led_req) begin
                led_pend_q <= 1'b1;
                led_val_q  <= led_val;
            end

            case (state_q)
                ST_IDLE: begin
                    retry_q <= '0;
                    if (rst_pend_q) begin
                        tx_data_q  <= CMD_RESET;
                        state_q    <= ST_SEND;
                        cmd_busy_q <= 1'b1;
                        rst_pend_q <= kbd_reset_req;
                    end else if (led_pend_q) begin
                        tx_data_q  <= CMD_SET_LED;
                        state_q    <= ST_SEND;
                        cmd_busy_q <= 1'b1;
                        led_pend_q <= led_req;
                    end
                end
                ST_SEND: begin
                    tx_start_q <= 1'b1;
                    state_q    <= ST_TXWAIT;
                end
                ST_TXWAIT: begin
                    if (!tx_error && tx_done) begin
                        state_q <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (rx_ack) begin
                        retry_q <= '0;
                        if (tx_data_q == CMD_RESET) begin
                            state_q <= ST_WAIT_BAT;
                        end else if (tx_data_q == CMD_SET_LED) begin
                            tx_data_q <= led_byte(led_val_q);
                            state_q   <= ST_SEND;
                        end else begin
                            state_q    <= ST_IDLE;
                            cmd_busy_q <= 1'b0;
                        end
                    end
                end
                ST_WAIT_BAT: begin
                    if (rx_bat_ok) begin
                        kbd_ok_q   <= 1'b1;
                        kbd_fail_q <= 1'b0;
                        state_q    <= ST_IDLE;
                        cmd_busy_q <= 1'b0;
                    end else if (rx_bat_fail || tmr_expired) begin
                        kbd_ok_q   <= 1'b0;
                        kbd_fail_q <= 1'b1;
                        state_q    <= ST_IDLE;
                        cmd_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cmd_busy_q <= 1'b0;
                end
            endcase

            // Retry overrides the per-state transition; tx_data_q still holds the byte.
            if (do_retry) begin
                if (retry_q == RW'(MAX_RETRY)) begin
                    kbd_fail_q <= 1'b1;
                    state_q    <= ST_IDLE;
                    cmd_busy_q <= 1'b0;
                end else begin
                    retry_q <= retry_q + RW'(1);
                    state_q <= ST_SEND;
                end
            end
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign scan_data  = scan_data_q;
    assign scan_valid = scan_valid_q;
    assign cmd_busy   = cmd_busy_q;
    assign kbd_ok     = kbd_ok_q;
    assign kbd_fail   = kbd_fail_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: transceiver and keyboard models, table-driven LED
// and forwarding vectors, randomized LED/resend runs and timeout sequences.
`timescale 1ns/1ps
module tb_ps2_host_ctrl;

    localparam int CLK_FREQ = 100000;   // 100 cycles per ms
    localparam int ACK_MS   = 20;
    localparam int BAT_MS   = 30;
    localparam int MAXR     = 3;
    localparam int FRAME    = 12;

    logic       clk, rst_n;
    logic [7:0] rx_data, tx_data, scan_data;
    logic       rx_valid, rx_error, tx_start, tx_busy, tx_error;
    logic       led_req, kbd_reset_req, scan_valid, cmd_busy, kbd_ok, kbd_fail;
    logic [2:0] led_val;

    ps2_host_ctrl #(
        .CLK_FREQ(CLK_FREQ), .ACK_TIMEOUT_MS(ACK_MS),
        .BAT_TIMEOUT_MS(BAT_MS), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_error(tx_error), .led_req(led_req),
        .led_val(led_val), .kbd_reset_req(kbd_reset_req), .scan_data(scan_data),
        .scan_valid(scan_valid), .cmd_busy(cmd_busy), .kbd_ok(kbd_ok),
        .kbd_fail(kbd_fail)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_starts = 0;
    int err_inject = 0;
    logic [7:0] done_q[$];
    logic [7:0] fwd_q[$];

    typedef struct {
        logic [2:0] led;
        int         resends;
        int         exp_ed;
        int         exp_dat;
        logic [7:0] exp_byte;
        logic       exp_fail;
    } led_vec_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transceiver: a frame lasts FRAME cycles; optionally ends in tx_error.
    initial begin
        int cnt;
        logic [7:0] cur;
        cnt = 0;
        cur = 8'h00;
        tx_busy = 1'b0;
        tx_error = 1'b0;
        forever begin
            @(negedge clk);
            tx_error = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_busy = 1'b0;
                    if (err_inject > 0) begin
                        err_inject--;
                        tx_error = 1'b1;
                    end else begin
                        done_q.push_back(cur);
                    end
                end
            end else if (tx_start) begin
                cur = tx_data;
                n_starts++;
                tx_busy = 1'b1;
                cnt = FRAME;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (scan_valid) fwd_q.push_back(scan_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input int limit, output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b = 8'h00;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_q.size() > 0) begin
                b = done_q.pop_front();
                ok = 1'b1;
                $display("tx byte %02h done at cycle %0d", b, cyc);
                break;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_led(input logic [2:0] v);
        @(negedge clk);
        led_req = 1'b1;
        led_val = v;
        @(negedge clk);
        led_req = 1'b0;
    endtask

    task automatic pulse_kbd_reset();
        @(negedge clk);
        kbd_reset_req = 1'b1;
        @(negedge clk);
        kbd_reset_req = 1'b0;
    endtask

    // Keyboard model: answers every completed frame until the line goes quiet.
    task automatic serve(input int ed_resends, input bit send_bat, input logic [7:0] bat,
                         output int n_ff, output int n_ed, output int n_dat,
                         output logic [7:0] last_dat);
        logic [7:0] b;
        bit ok;
        n_ff = 0; n_ed = 0; n_dat = 0; last_dat = 8'h00;
        for (int k = 0; k < 16; k++) begin
            wait_frame(150, b, ok);
            if (!ok) break;
            if (b == 8'hFF) begin
                n_ff++;
                send_rx(8'hFA);
                if (send_bat) begin
                    repeat (5) @(negedge clk);
                    send_rx(bat);
                end
            end else if (b == 8'hED) begin
                n_ed++;
                send_rx((n_ed <= ed_resends) ? 8'hFE : 8'hFA);
            end else begin
                n_dat++;
                last_dat = b;
                send_rx(8'hFA);
            end
        end
    endtask

    initial begin
        led_vec_t   led_tab[4];
        logic [7:0] fwd_tab[6];
        int n_ff, n_ed, n_dat, s0, t_prev, gap;
        logic [7:0] last, b;
        bit ok, exp_fail;

        led_tab[0] = '{3'b101, 0, 1, 1, 8'h05, 1'b0};
        led_tab[1] = '{3'b010, 2, 3, 1, 8'h02, 1'b0};
        led_tab[2] = '{3'b111, 1, 2, 1, 8'h07, 1'b0};
        led_tab[3] = '{3'b011, 4, 4, 0, 8'h00, 1'b1};
        fwd_tab[0] = 8'h1C; fwd_tab[1] = 8'hFA; fwd_tab[2] = 8'hFE;
        fwd_tab[3] = 8'hAA; fwd_tab[4] = 8'hFC; fwd_tab[5] = 8'hF0;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
        led_req = 1'b0; led_val = 3'b000; kbd_reset_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_scan_valid", scan_valid, 0);
        check("rst_cmd_busy", cmd_busy, 0);
        check("rst_kbd_ok", kbd_ok, 0);
        check("rst_kbd_fail", kbd_fail, 0);

        // Power-up reset sequence
        rst_n = 1'b1;
        @(negedge clk);
        check("busy_after_release", cmd_busy, 1);
        @(negedge clk);
        check("tx_start_latency", tx_start, 1);
        check("tx_data_reset_cmd", tx_data, 8'hFF);
        serve(0, 1'b1, 8'hAA, n_ff, n_ed, n_dat, last);
        check("boot_ff_sends", n_ff, 1);
        check("boot_ed_sends", n_ed, 0);
        check("boot_kbd_ok", kbd_ok, 1);
        check("boot_kbd_fail", kbd_fail, 0);
        check("boot_cmd_busy", cmd_busy, 0);
        check("boot_no_forward", fwd_q.size(), 0);

        // Forwarding in IDLE, including reply codes
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rx_data = fwd_tab[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            check("fwd_valid", scan_valid, 1);
            check("fwd_data", scan_data, fwd_tab[i]);
            @(negedge clk);
            check("fwd_strobe_len", scan_valid, 0);
        end
        fwd_q.delete();

        // LED command vectors
        for (int i = 0; i < 4; i++) begin
            pulse_led(led_tab[i].led);
            serve(led_tab[i].resends, 1'b1, 8'hAA, n_ff, n_ed, n_dat, last);
            check("led_ed_sends", n_ed, led_tab[i].exp_ed);
            check("led_data_sends", n_dat, led_tab[i].exp_dat);
            if (led_tab[i].exp_dat > 0) check("led_data_byte", last, led_tab[i].exp_byte);
            check("led_ff_sends", n_ff, 0);
            check("led_cmd_busy", cmd_busy, 0);
            check("led_kbd_fail", kbd_fail, led_tab[i].exp_fail);
        end

        // Scancode during WAIT_ACK is forwarded, the ACK is not
        fwd_q.delete();
        pulse_led(3'b001);
        wait_frame(200, b, ok);
        check("wack_cmd", b, 8'hED);
        send_rx(8'h1C);
        send_rx(8'hFA);
        wait_frame(200, b, ok);
        check("wack_data", b, 8'h01);
        send_rx(8'hFA);
        repeat (20) @(negedge clk);
        check("wack_fwd_count", fwd_q.size(), 1);
        if (fwd_q.size() > 0) check("wack_fwd_byte", fwd_q[0], 8'h1C);
        check("wack_cmd_busy", cmd_busy, 0);
        fwd_q.delete();

        // Two LED requests while a reset runs: only the latest is sent, once
        pulse_kbd_reset();
        wait_frame(200, b, ok);
        check("rl_reset_cmd", b, 8'hFF);
        pulse_led(3'b001);
        pulse_led(3'b110);
        send_rx(8'hFA);
        repeat (3) @(negedge clk);
        send_rx(8'hAA);
        serve(0, 1'b1, 8'hAA, n_ff, n_ed, n_dat, last);
        check("rl_ed_sends", n_ed, 1);
        check("rl_data_sends", n_dat, 1);
        check("rl_data_byte", last, 8'h06);
        check("rl_kbd_ok", kbd_ok, 1);
        check("rl_kbd_fail", kbd_fail, 0);
        exp_fail = 1'b0;

        // Line-level transmit error causes a resend of the same byte
        s0 = n_starts;
        err_inject = 1;
        pulse_led(3'b100);
        serve(0, 1'b1, 8'hAA, n_ff, n_ed, n_dat, last);
        check("txerr_starts", n_starts - s0, 3);
        check("txerr_data_byte", last, 8'h04);
        check("txerr_kbd_fail", kbd_fail, 0);

        // Randomized LED runs against a retry-budget model
        for (int it = 0; it < 6; it++) begin
            logic [2:0] v;
            int r, e_ed, e_dat;
            v = 3'($urandom_range(0, 7));
            r = int'($urandom_range(0, 4));
            e_ed  = (r > MAXR) ? MAXR + 1 : r + 1;
            e_dat = (r > MAXR) ? 0 : 1;
            if (r > MAXR) exp_fail = 1'b1;
            $display("random run %0d: leds %03b resends %0d", it, v, r);
            pulse_led(v);
            serve(r, 1'b1, 8'hAA, n_ff, n_ed, n_dat, last);
            check("rnd_ed_sends", n_ed, e_ed);
            check("rnd_data_sends", n_dat, e_dat);
            if (e_dat > 0) check("rnd_data_byte", last, {5'b0, v});
            check("rnd_kbd_fail", kbd_fail, exp_fail);
            check("rnd_kbd_ok", kbd_ok, 1);
        end

        // BAT never arrives
        pulse_kbd_reset();
        serve(0, 1'b0, 8'h00, n_ff, n_ed, n_dat, last);
        check("battmo_ff_sends", n_ff, 1);
        for (int i = 0; i < 4000 && cmd_busy; i++) @(negedge clk);
        check("battmo_cmd_busy", cmd_busy, 0);
        check("battmo_kbd_fail", kbd_fail, 1);
        check("battmo_kbd_ok", kbd_ok, 0);

        pulse_kbd_reset();
        serve(0, 1'b1, 8'hAA, n_ff, n_ed, n_dat, last);
        check("reboot_kbd_ok", kbd_ok, 1);
        check("reboot_kbd_fail", kbd_fail, 0);

        // No ACK at all: 1 + MAXR sends about ACK_MS apart, then failure
        pulse_kbd_reset();
        t_prev = 0;
        for (int k = 0; k <= MAXR; k++) begin
            wait_frame(2500, b, ok);
            check("noack_frame_seen", ok, 1);
            check("noack_byte", b, 8'hFF);
            gap = cyc - t_prev;
            if (k > 0) check("noack_gap_in_range",
                             (gap >= ACK_MS * 100) && (gap <= ACK_MS * 100 + 150), 1);
            t_prev = cyc;
        end
        for (int i = 0; i < 2500 && cmd_busy; i++) @(negedge clk);
        check("noack_cmd_busy", cmd_busy, 0);
        check("noack_kbd_fail", kbd_fail, 1);
        s0 = n_starts;
        repeat (300) @(negedge clk);
        check("noack_no_more_sends", n_starts - s0, 0);

        // BAT failure code 0xFC is consumed and reported
        fwd_q.delete();
        pulse_kbd_reset();
        serve(0, 1'b1, 8'hFC, n_ff, n_ed, n_dat, last);
        check("batfc_kbd_fail", kbd_fail, 1);
        check("batfc_kbd_ok", kbd_ok, 0);
        check("batfc_no_forward", fwd_q.size(), 0);

        // Asynchronous reset mid-sequence aborts at once and restarts reset
        pulse_led(3'b110);
        wait_frame(200, b, ok);
        check("abort_cmd", b, 8'hED);
        #3 rst_n = 1'b0;
        #1;
        check("abort_cmd_busy", cmd_busy, 0);
        check("abort_kbd_fail", kbd_fail, 0);
        check("abort_tx_data", tx_data, 0);
        repeat (20) @(negedge clk);
        done_q.delete();
        fwd_q.delete();
        rst_n = 1'b1;
        serve(0, 1'b1, 8'hAA, n_ff, n_ed, n_dat, last);
        check("abort_ff_sends", n_ff, 1);
        check("abort_ed_sends", n_ed, 0);
        check("abort_kbd_ok", kbd_ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
